// File: rtl/icache_refill_ctrl_if.sv
// rtl/icache_refill_ctrl_if.sv - miss request, memory bus and data RAM signals of the icache refill controller
interface icache_refill_ctrl_if #(
    parameter int LINE_WORDS = 8,
    parameter int INDEX_W    = 7
);
    localparam int ADDR_W = INDEX_W + $clog2(LINE_WORDS);

    logic              miss_req;
    logic [31:0]       miss_addr;
    logic              miss_ack;
    logic              rd_req;
    logic [31:0]       rd_addr;
    logic              rd_rdy;
    logic              ret_valid;
    logic              ret_last;
    logic [31:0]       ret_data;
    logic              ram_en;
    logic [3:0]        ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              crit_valid;
    logic [31:0]       crit_data;
    logic              err;

    modport master (
        input  miss_req, miss_addr, rd_rdy, ret_valid, ret_last, ret_data,
        output miss_ack, rd_req, rd_addr, ram_en, ram_wen, ram_addr, ram_wdata,
               crit_valid, crit_data, err
    );

    modport slave (
        output miss_req, miss_addr, rd_rdy, ret_valid, ret_last, ret_data,
        input  miss_ack, rd_req, rd_addr, ram_en, ram_wen, ram_addr, ram_wdata,
               crit_valid, crit_data, err
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - icache line refill sequencer; ICACHE_CRITICAL_WORD_FIRST_EN selects wrapping critical-word-first bursts
module icache_refill_ctrl #(
    parameter int LINE_WORDS = 8,
    parameter int INDEX_W    = 7
) (
    input  logic                 clk,
    input  logic                 resetn,
    icache_refill_ctrl_if.master bus
);
    localparam int          OFF_W     = $clog2(LINE_WORDS);
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RECV,
        DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [INDEX_W-1:0] index_q;
    logic [OFF_W-1:0]   offset_q;
    logic [OFF_W-1:0]   count_q;
    logic [OFF_W-1:0]   ptr_q;
    logic [31:0]        rd_addr_q;
    logic               err_q;

    logic accept;
    logic beat;
    logic last_beat;

    assign accept    = (state_q == IDLE) && bus.miss_req;
    assign beat      = (state_q == RECV) && bus.ret_valid;
    assign last_beat = beat && (count_q == OFF_W'(LINE_WORDS - 1));

    assign bus.rd_addr = rd_addr_q;
    assign bus.err     = err_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // RAM-side outputs are driven straight from the incoming beat so the
    // write lands in the same cycle; no backpressure exists toward the bus.
    always_comb begin
        state_d        = state_q;
        bus.rd_req     = 1'b0;
        bus.miss_ack   = 1'b0;
        bus.ram_en     = 1'b0;
        bus.ram_wen    = 4'h0;
        bus.ram_addr   = '0;
        bus.ram_wdata  = 32'h0;
        bus.crit_valid = 1'b0;
        bus.crit_data  = 32'h0;
        case (state_q)
            IDLE: begin
                if (bus.miss_req) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                bus.rd_req = 1'b1;
                if (bus.rd_rdy) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (beat) begin
                    bus.ram_en    = 1'b1;
                    bus.ram_wen   = 4'hF;
                    bus.ram_addr  = {index_q, ptr_q};
                    bus.ram_wdata = bus.ret_data;
                    if (ptr_q == offset_q) begin
                        bus.crit_valid = 1'b1;
                        bus.crit_data  = bus.ret_data;
                    end
                end
                if (last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.miss_ack = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            index_q   <= '0;
            offset_q  <= '0;
            count_q   <= '0;
            ptr_q     <= '0;
            rd_addr_q <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                index_q  <= bus.miss_addr[2+OFF_W +: INDEX_W];
                offset_q <= bus.miss_addr[2 +: OFF_W];
                count_q  <= '0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
                ptr_q     <= bus.miss_addr[2 +: OFF_W];
                rd_addr_q <= bus.miss_addr & ~32'h3;
`else
                ptr_q     <= '0;
                rd_addr_q <= bus.miss_addr & LINE_MASK;
`endif
            end
            // Completion is decided by the beat count alone; ret_last only
            // feeds the sticky consistency flag.
            if (beat) begin
                count_q <= count_q + 1'b1;
                ptr_q   <= ptr_q + 1'b1;
                if (bus.ret_last != last_beat) begin
                    err_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - self-checking bench for icache_refill_ctrl
module tb_icache_refill_ctrl;
    localparam int LW = 8;
    localparam int IW = 7;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic clk;
    logic resetn;
    int   checks;
    int   failures;
    logic err_exp;

    icache_refill_ctrl_if #(.LINE_WORDS(LW), .INDEX_W(IW)) bus ();

    icache_refill_ctrl #(.LINE_WORDS(LW), .INDEX_W(IW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] addr;
        int          rdy_delay;
        int          gap;
        int          last_beat;
        bit          hold;
        logic [31:0] exp_rd;
        int          exp_crit;
        logic        exp_err;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_rd_addr(input logic [31:0] a);
        if (CWF) return a - (a % 4);
        return a - (a % (LW * 4));
    endfunction

    function automatic int m_off(input logic [31:0] a);
        return int'((a / 4) % LW);
    endfunction

    function automatic int m_start(input logic [31:0] a);
        return CWF ? m_off(a) : 0;
    endfunction

    function automatic int m_crit(input logic [31:0] a);
        return (m_off(a) - m_start(a) + LW) % LW;
    endfunction

    function automatic int m_ram_addr(input logic [31:0] a, input int k);
        int index;
        index = int'((a / (LW * 4)) % (1 << IW));
        return index * LW + (m_start(a) + k) % LW;
    endfunction

    // Entered and left at posedge+1 of a cycle in which the controller idles.
    task automatic refill(input logic [31:0] addr, input int rdy_delay, input int gap,
                          input int last_beat, input logic [31:0] exp_rd,
                          input int exp_crit, input bit hold);
        logic [31:0] d;
        int          g;
        bus.miss_req  = 1'b1;
        bus.miss_addr = addr;
        bus.ret_valid = 1'b1;
        bus.ret_last  = 1'b1;
        bus.ret_data  = $urandom;
        #1;
        chk("idle_rd_req", bus.rd_req, 0);
        chk("stray_ram_en", bus.ram_en, 0);
        @(posedge clk); #1;
        bus.ret_valid = 1'b0;
        bus.ret_last  = 1'b0;
        for (int i = 0; i <= rdy_delay; i++) begin
            bus.rd_rdy = (i == rdy_delay);
            #1;
            chk("req_rd_req", bus.rd_req, 1);
            chk("req_rd_addr", bus.rd_addr, exp_rd);
            chk("req_ram_en", bus.ram_en, 0);
            @(posedge clk); #1;
        end
        bus.rd_rdy = 1'b0;
        for (int k = 0; k < LW; k++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int j = 0; j < g; j++) begin
                bus.ret_valid = 1'b0;
                #1;
                chk("gap_ram_en", bus.ram_en, 0);
                chk("gap_crit_valid", bus.crit_valid, 0);
                chk("gap_miss_ack", bus.miss_ack, 0);
                @(posedge clk); #1;
            end
            d             = $urandom;
            bus.ret_valid = 1'b1;
            bus.ret_last  = (k == last_beat);
            bus.ret_data  = d;
            #1;
            chk("beat_ram_en", bus.ram_en, 1);
            chk("beat_ram_wen", bus.ram_wen, 4'hF);
            chk("beat_ram_addr", bus.ram_addr, m_ram_addr(addr, k));
            chk("beat_ram_wdata", bus.ram_wdata, d);
            chk("beat_crit_valid", bus.crit_valid, (k == exp_crit));
            if (k == exp_crit) chk("beat_crit_data", bus.crit_data, d);
            chk("beat_miss_ack", bus.miss_ack, 0);
            if ((k == LW - 1) != (k == last_beat)) err_exp = 1'b1;
            @(posedge clk); #1;
        end
        bus.ret_valid = 1'b0;
        bus.ret_last  = 1'b0;
        #1;
        chk("done_miss_ack", bus.miss_ack, 1);
        chk("done_ram_en", bus.ram_en, 0);
        chk("done_err", bus.err, err_exp);
        if (!hold) bus.miss_req = 1'b0;
        @(posedge clk); #1;
        chk("post_miss_ack", bus.miss_ack, 0);
        chk("post_rd_req", bus.rd_req, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_req"}, bus.rd_req, 0);
        chk({tag, "_rd_addr"}, bus.rd_addr, 0);
        chk({tag, "_ram_en"}, bus.ram_en, 0);
        chk({tag, "_ram_wen"}, bus.ram_wen, 0);
        chk({tag, "_ram_addr"}, bus.ram_addr, 0);
        chk({tag, "_ram_wdata"}, bus.ram_wdata, 0);
        chk({tag, "_miss_ack"}, bus.miss_ack, 0);
        chk({tag, "_crit_valid"}, bus.crit_valid, 0);
        chk({tag, "_crit_data"}, bus.crit_data, 0);
        chk({tag, "_err"}, bus.err, 0);
    endtask

    initial begin
        logic [31:0] a;
        int          lb;
        checks   = 0;
        failures = 0;
        err_exp  = 1'b0;

        tbl[0] = '{32'h0000_1A14, 0, 0, 7, 1'b0, CWF ? 32'h0000_1A14 : 32'h0000_1A00, CWF ? 0 : 5, 1'b0};
        tbl[1] = '{32'h0000_1A14, 3, 2, 7, 1'b0, CWF ? 32'h0000_1A14 : 32'h0000_1A00, CWF ? 0 : 5, 1'b0};
        tbl[2] = '{32'h0000_1A14, 0, 0, 6, 1'b0, CWF ? 32'h0000_1A14 : 32'h0000_1A00, CWF ? 0 : 5, 1'b1};
        tbl[3] = '{32'h0000_0FFC, 1, 1, 7, 1'b0, CWF ? 32'h0000_0FFC : 32'h0000_0FE0, CWF ? 0 : 7, 1'b1};
        tbl[4] = '{32'hFFFF_FFE0, 0, 0, 7, 1'b0, 32'hFFFF_FFE0, 0, 1'b1};
        tbl[5] = '{32'h1234_5672, 2, 0, 7, 1'b1, CWF ? 32'h1234_5670 : 32'h1234_5660, CWF ? 0 : 4, 1'b1};
        tbl[6] = '{32'h1234_5672, 0, 1, 7, 1'b0, CWF ? 32'h1234_5670 : 32'h1234_5660, CWF ? 0 : 4, 1'b1};

        resetn        = 1'b0;
        bus.miss_req  = 1'b0;
        bus.miss_addr = 32'h0;
        bus.rd_rdy    = 1'b0;
        bus.ret_valid = 1'b0;
        bus.ret_last  = 1'b0;
        bus.ret_data  = 32'h0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            refill(tbl[i].addr, tbl[i].rdy_delay, tbl[i].gap, tbl[i].last_beat,
                   tbl[i].exp_rd, tbl[i].exp_crit, tbl[i].hold);
            chk("tbl_err", bus.err, tbl[i].exp_err);
        end

        // Reset in the middle of receiving a line.
        bus.miss_req  = 1'b1;
        bus.miss_addr = 32'h0000_2468;
        @(posedge clk); #1;
        bus.rd_rdy = 1'b1;
        @(posedge clk); #1;
        bus.rd_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.ret_valid = 1'b1;
            bus.ret_data  = $urandom;
            @(posedge clk); #1;
        end
        bus.ret_valid = 1'b1;
        bus.ret_data  = 32'hDEAD_BEEF;
        resetn        = 1'b0;
        #1;
        chk_all_zero("midreset");
        bus.ret_valid = 1'b0;
        bus.miss_req  = 1'b0;
        err_exp       = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("after_reset_miss_ack", bus.miss_ack, 0);
            chk("after_reset_rd_req", bus.rd_req, 0);
            chk("after_reset_ram_en", bus.ram_en, 0);
        end

        for (int r = 0; r < 25; r++) begin
            a  = $urandom;
            lb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, LW - 1)) : LW - 1;
            refill(a, int'($urandom_range(0, 3)), -1, lb, m_rd_addr(a), m_crit(a),
                   ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
